// File: rtl/ibex_ifetch_pmp_err_tracker.sv
// Purpose: remembers the last DEPTH distinct fetch addresses and whether each hit a PMP error, plus fetch/error stats.
// Latency: query result one cycle after query_valid_i; occupancy and counters reflect the post-edge state.
// Backpressure: none; a fetch and a query can be accepted every cycle.
module ibex_ifetch_pmp_err_tracker #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid_i,
  input  logic [ADDR_W-1:0]        fetch_addr_i,
  input  logic                     fetch_pmp_err_i,
  input  logic                     flush_i,
  input  logic                     query_valid_i,
  input  logic [ADDR_W-1:0]        query_addr_i,
  output logic                     query_resp_valid_o,
  output logic                     query_hit_o,
  output logic                     query_pmp_err_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [CNT_W-1:0]         fetch_count_o,
  output logic [CNT_W-1:0]         err_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic              valid_q [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic              err_q   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [OCC_W-1:0]  occ_q;
  logic [CNT_W-1:0]  fetch_cnt_q;
  logic [CNT_W-1:0]  err_cnt_q;

  logic              resp_vld_q;
  logic              resp_hit_q;
  logic              resp_err_q;

  logic              f_hit;
  logic [PTR_W-1:0]  f_idx;
  logic              q_hit;
  logic              q_err;

  // Look up the fetch address in the pre-edge table; addresses are unique so at most one entry matches.
  always_comb begin
    f_hit = 1'b0;
    f_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == fetch_addr_i)) begin
        f_hit = 1'b1;
        f_idx = PTR_W'(i);
      end
    end
  end

  // Look up the query address in the pre-edge table (no bypass of this cycle's fetch or flush).
  always_comb begin
    q_hit = 1'b0;
    q_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == query_addr_i)) begin
        q_hit = 1'b1;
        q_err = err_q[i];
      end
    end
  end

  // Table update: flush first, then the fetch either refreshes a matching entry or allocates at wr_ptr.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        err_q[i]   <= 1'b0;
      end
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (fetch_valid_i) begin
        if (flush_i) begin
          // After a flush the table is empty, so the fetch always lands in slot 0.
          valid_q[0] <= 1'b1;
          addr_q[0]  <= fetch_addr_i;
          err_q[0]   <= fetch_pmp_err_i;
          wr_ptr_q   <= PTR_W'(1);
          occ_q      <= OCC_W'(1);
        end else if (f_hit) begin
          err_q[f_idx] <= fetch_pmp_err_i;
        end else begin
          valid_q[wr_ptr_q] <= 1'b1;
          addr_q[wr_ptr_q]  <= fetch_addr_i;
          err_q[wr_ptr_q]   <= fetch_pmp_err_i;
          wr_ptr_q          <= wr_ptr_q + 1'b1;
          // Entries fill in ring order from slot 0, so an invalid slot at wr_ptr means the table is not yet full.
          if (!valid_q[wr_ptr_q]) begin
            occ_q <= occ_q + 1'b1;
          end
        end
      end else if (flush_i) begin
        wr_ptr_q <= '0;
        occ_q    <= '0;
      end
    end
  end

  // Saturating statistics; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (fetch_valid_i) begin
      if (fetch_cnt_q != '1) begin
        fetch_cnt_q <= fetch_cnt_q + 1'b1;
      end
      if (fetch_pmp_err_i && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  // Register the query response; hit and error are forced low when no query was made.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_vld_q <= 1'b0;
      resp_hit_q <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      resp_vld_q <= query_valid_i;
      resp_hit_q <= query_valid_i & q_hit;
      resp_err_q <= query_valid_i & q_err;
    end
  end

  assign query_resp_valid_o = resp_vld_q;
  assign query_hit_o        = resp_hit_q;
  assign query_pmp_err_o    = resp_err_q;
  assign occupancy_o        = occ_q;
  assign fetch_count_o      = fetch_cnt_q;
  assign err_count_o        = err_cnt_q;

endmodule
